// File: rtl/multicycle_controller_if.sv
// Unified memory port between the multi-cycle controller and memory.
// The controller issues requests; memory answers with mem_ready.
interface multicycle_controller_if;
    logic mem_read;
    logic mem_write;
    logic iord;
    logic mem_ready;

    modport master (
        output mem_read,
        output mem_write,
        output iord,
        input  mem_ready
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  iord,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM: fetch/decode/execute/memory/writeback,
// memory handshake with timeout, illegal-op trap, retired counter.
module multicycle_controller #(
    parameter int ALUOP_W     = 6,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [5:0]         opcode,
    input  logic [5:0]         func,
    input  logic               zero,
    multicycle_controller_if.master mem,
    output logic               ir_write,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic [1:0]         pc_src,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               fault,
    output logic [1:0]         fault_code,
    output logic [CNT_W-1:0]   retired
);

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, EXEC_R, WB_R,
        EXEC_I, WB_I, MEM_ADDR, MEM_RD, WB_MEM,
        MEM_WR, BRANCH, JUMP, FAULT
    } state_t;

    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLTU = 6'b101011;

    localparam int TW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0] TLAST = TW'(MEM_TIMEOUT - 1);

    state_t        state, state_n;
    logic [TW-1:0] cnt;
    logic [1:0]    code_n;
    logic          retire;
    logic          rd_req, wr_req, addr_sel;
    logic          func_ok;
    logic          is_r, is_mem, is_imm, is_br, is_j;
    logic [5:0]    imm_f;
    logic          expired;

    assign mem.mem_read  = rd_req;
    assign mem.mem_write = wr_req;
    assign mem.iord      = addr_sel;
    assign fault         = (state == FAULT);
    assign expired       = !mem.mem_ready && (cnt == TLAST);

    // Classify the instruction held in the instruction register
    always_comb begin
        func_ok = 1'b0;
        case (func)
            F_ADD, F_SUB, F_AND, F_OR,
            F_XOR, F_SLT, F_SLTU: func_ok = 1'b1;
            default:              func_ok = 1'b0;
        endcase
        is_r   = (opcode == 6'b000000);
        is_mem = (opcode == 6'b100011) || (opcode == 6'b101011);
        is_br  = (opcode == 6'b000100) || (opcode == 6'b000101);
        is_j   = (opcode == 6'b000010);
        is_imm = 1'b1;
        imm_f  = F_ADD;
        case (opcode)
            6'b001000: imm_f = F_ADD;
            6'b001100: imm_f = F_AND;
            6'b001101: imm_f = F_OR;
            6'b001110: imm_f = F_XOR;
            6'b001010: imm_f = F_SLT;
            6'b001011: imm_f = F_SLTU;
            default:   is_imm = 1'b0;
        endcase
    end

    // Next state, control outputs and fault cause for the current state
    always_comb begin
        state_n       = state;
        code_n        = 2'b00;
        retire        = 1'b0;
        rd_req        = 1'b0;
        wr_req        = 1'b0;
        addr_sel      = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 2'd0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'd0;
        alu_op        = '0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        case (state)
            IDLE: state_n = FETCH;
            FETCH: begin
                rd_req    = 1'b1;
                alu_src_b = 2'd1;
                alu_op    = ALUOP_W'(F_ADD);
                ir_write  = mem.mem_ready;
                pc_write  = mem.mem_ready;
                if (mem.mem_ready) begin
                    state_n = DECODE;
                end else if (expired) begin
                    state_n = FAULT;
                    code_n  = 2'b10;
                end
            end
            DECODE: begin
                alu_src_b = 2'd3;
                alu_op    = ALUOP_W'(F_ADD);
                unique case (1'b1)
                    is_r && func_ok: state_n = EXEC_R;
                    is_mem:          state_n = MEM_ADDR;
                    is_imm:          state_n = EXEC_I;
                    is_br:           state_n = BRANCH;
                    is_j:            state_n = JUMP;
                    default: begin
                        state_n = FAULT;
                        code_n  = 2'b01;
                    end
                endcase
            end
            EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_W'(func);
                state_n   = WB_R;
            end
            WB_R: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                retire    = 1'b1;
                state_n   = FETCH;
            end
            EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                alu_op    = ALUOP_W'(imm_f);
                state_n   = WB_I;
            end
            WB_I: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_n   = FETCH;
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                alu_op    = ALUOP_W'(F_ADD);
                state_n   = opcode[3] ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                rd_req   = 1'b1;
                addr_sel = 1'b1;
                if (mem.mem_ready) begin
                    state_n = WB_MEM;
                end else if (expired) begin
                    state_n = FAULT;
                    code_n  = 2'b10;
                end
            end
            WB_MEM: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_n    = FETCH;
            end
            MEM_WR: begin
                wr_req   = 1'b1;
                addr_sel = 1'b1;
                if (mem.mem_ready) begin
                    retire  = 1'b1;
                    state_n = FETCH;
                end else if (expired) begin
                    state_n = FAULT;
                    code_n  = 2'b10;
                end
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALUOP_W'(F_SUB);
                pc_src        = 2'd1;
                pc_write_cond = opcode[0] ? !zero : zero;
                retire        = 1'b1;
                state_n       = FETCH;
            end
            JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'd2;
                retire   = 1'b1;
                state_n  = FETCH;
            end
            FAULT:   state_n = FAULT;
            default: state_n = IDLE;
        endcase
    end

    // State register; reset aborts any access in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    // Wait counter restarts whenever a new state is entered
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (state_n != state) begin
            cnt <= '0;
        end else if (!mem.mem_ready &&
                     (state == FETCH || state == MEM_RD ||
                      state == MEM_WR)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Fault cause is latched on entry and held until reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            fault_code <= 2'b00;
        else if (state_n == FAULT && state != FAULT)
            fault_code <= code_n;
    end

    // Retired count bumps on each instruction's final cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    retired <= '0;
        else if (retire) retired <= retired + 1'b1;
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: vector table plus
// hand sequences for faults, timeout, wrap and async reset.
module tb_multicycle_controller;

    localparam logic [5:0] ADD  = 6'b100000;
    localparam logic [5:0] SUB  = 6'b100010;
    localparam logic [5:0] ORF  = 6'b100101;
    localparam logic [5:0] SLTU = 6'b101011;
    localparam logic [5:0] OP_R  = 6'b000000;
    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_SW = 6'b101011;
    localparam logic [5:0] OP_ORI = 6'b001101;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;
    localparam logic [5:0] OP_J   = 6'b000010;

    logic       clk;
    logic       reset_n;
    logic [5:0] opcode, func;
    logic       zero;
    logic       ir_write, pc_write, pc_write_cond;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [5:0] alu_op;
    logic       reg_dst, mem_to_reg, reg_write;
    logic       fault;
    logic [1:0] fault_code;
    logic [3:0] retired;

    int errors = 0;
    int checks = 0;

    multicycle_controller_if bus ();

    multicycle_controller #(
        .ALUOP_W(6), .MEM_TIMEOUT(4), .CNT_W(4)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .opcode(opcode), .func(func), .zero(zero),
        .mem(bus),
        .ir_write(ir_write), .pc_write(pc_write),
        .pc_write_cond(pc_write_cond), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .fault(fault), .fault_code(fault_code),
        .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [19:0] dcw;
    assign dcw = {bus.mem_read, bus.mem_write, bus.iord,
                  ir_write, pc_write, pc_write_cond, pc_src,
                  alu_src_a, alu_src_b, alu_op,
                  reg_dst, mem_to_reg, reg_write};

    function automatic logic [19:0] cw(
        input logic mr, mw, io, irw, pcw, pcwc,
        input logic [1:0] ps, input logic asa,
        input logic [1:0] asb, input logic [5:0] aop,
        input logic rd, m2r, rw);
        return {mr, mw, io, irw, pcw, pcwc, ps,
                asa, asb, aop, rd, m2r, rw};
    endfunction

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        rdy;
        logic [19:0] exp;
        logic [3:0]  ret;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h",
                     nm, act, exp);
        end
    endtask

    task automatic add(input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic rdy,
                       input logic [19:0] exp,
                       input logic [3:0] ret);
        vec_t v;
        v.op = op; v.fn = fn; v.z = z; v.rdy = rdy;
        v.exp = exp; v.ret = ret;
        tv.push_back(v);
    endtask

    // Advance one clock, drive inputs, settle at the falling edge
    task automatic step(input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input logic rdy);
        @(posedge clk);
        #1;
        opcode = op; func = fn; zero = z; bus.mem_ready = rdy;
        @(negedge clk);
    endtask

    // Reset with checks during reset and in IDLE afterwards
    task automatic do_reset;
        @(negedge clk);
        reset_n = 1'b0;
        bus.mem_ready = 1'b0;
        #1;
        chk("rst_ctrl", 32'(dcw), 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_code", {30'd0, fault_code}, 32'd0);
        chk("rst_ret", {28'd0, retired}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("idle_ctrl", 32'(dcw), 32'd0);
    endtask

    logic [19:0] F1, F0, DEC, EXR, WBR, WBI, MAD;
    logic [19:0] MRD, WBM, MWR, JMP;

    initial begin
        reset_n = 1'b0;
        opcode = '0; func = '0; zero = 1'b0;
        bus.mem_ready = 1'b0;

        F1  = cw(1,0,0,1,1,0,2'd0,0,2'd1,ADD,0,0,0);
        F0  = cw(1,0,0,0,0,0,2'd0,0,2'd1,ADD,0,0,0);
        DEC = cw(0,0,0,0,0,0,2'd0,0,2'd3,ADD,0,0,0);
        EXR = cw(0,0,0,0,0,0,2'd0,1,2'd0,ADD,0,0,0);
        WBR = cw(0,0,0,0,0,0,2'd0,0,2'd0,6'd0,1,0,1);
        WBI = cw(0,0,0,0,0,0,2'd0,0,2'd0,6'd0,0,0,1);
        MAD = cw(0,0,0,0,0,0,2'd0,1,2'd2,ADD,0,0,0);
        MRD = cw(1,0,1,0,0,0,2'd0,0,2'd0,6'd0,0,0,0);
        WBM = cw(0,0,0,0,0,0,2'd0,0,2'd0,6'd0,0,1,1);
        MWR = cw(0,1,1,0,0,0,2'd0,0,2'd0,6'd0,0,0,0);
        JMP = cw(0,0,0,0,1,0,2'd2,0,2'd0,6'd0,0,0,0);

        // ADD
        add(OP_R, ADD, 0, 1, F1, 0);
        add(OP_R, ADD, 0, 1, DEC, 0);
        add(OP_R, ADD, 0, 1, EXR, 0);
        add(OP_R, ADD, 0, 1, WBR, 0);
        // ORI
        add(OP_ORI, 0, 0, 1, F1, 1);
        add(OP_ORI, 0, 0, 1, DEC, 1);
        add(OP_ORI, 0, 0, 1,
            cw(0,0,0,0,0,0,2'd0,1,2'd2,ORF,0,0,0), 1);
        add(OP_ORI, 0, 0, 1, WBI, 1);
        // LW, three wait cycles: 8 cycles in all
        add(OP_LW, 0, 0, 1, F1, 2);
        add(OP_LW, 0, 0, 1, DEC, 2);
        add(OP_LW, 0, 0, 1, MAD, 2);
        add(OP_LW, 0, 0, 0, MRD, 2);
        add(OP_LW, 0, 0, 0, MRD, 2);
        add(OP_LW, 0, 0, 0, MRD, 2);
        add(OP_LW, 0, 0, 1, MRD, 2);
        add(OP_LW, 0, 0, 1, WBM, 2);
        // SW, zero wait
        add(OP_SW, 0, 0, 1, F1, 3);
        add(OP_SW, 0, 0, 1, DEC, 3);
        add(OP_SW, 0, 0, 1, MAD, 3);
        add(OP_SW, 0, 0, 1, MWR, 3);
        // BEQ zero=1 taken
        add(OP_BEQ, 0, 1, 1, F1, 4);
        add(OP_BEQ, 0, 1, 1, DEC, 4);
        add(OP_BEQ, 0, 1, 1,
            cw(0,0,0,0,0,1,2'd1,1,2'd0,SUB,0,0,0), 4);
        // BNE zero=1 not taken
        add(OP_BNE, 0, 1, 1, F1, 5);
        add(OP_BNE, 0, 1, 1, DEC, 5);
        add(OP_BNE, 0, 1, 1,
            cw(0,0,0,0,0,0,2'd1,1,2'd0,SUB,0,0,0), 5);
        // BNE zero=0 taken
        add(OP_BNE, 0, 0, 1, F1, 6);
        add(OP_BNE, 0, 0, 1, DEC, 6);
        add(OP_BNE, 0, 0, 1,
            cw(0,0,0,0,0,1,2'd1,1,2'd0,SUB,0,0,0), 6);
        // SLTIU
        add(OP_SLTIU, 0, 0, 1, F1, 7);
        add(OP_SLTIU, 0, 0, 1, DEC, 7);
        add(OP_SLTIU, 0, 0, 1,
            cw(0,0,0,0,0,0,2'd0,1,2'd2,SLTU,0,0,0), 7);
        add(OP_SLTIU, 0, 0, 1, WBI, 7);
        // J with one fetch wait cycle
        add(OP_J, 0, 0, 0, F0, 8);
        add(OP_J, 0, 0, 1, F1, 8);
        add(OP_J, 0, 0, 1, DEC, 8);
        add(OP_J, 0, 0, 1, JMP, 8);

        do_reset();
        foreach (tv[i]) begin
            step(tv[i].op, tv[i].fn, tv[i].z, tv[i].rdy);
            chk($sformatf("vec%0d_ctrl", i), 32'(dcw),
                32'(tv[i].exp));
            chk($sformatf("vec%0d_ret", i), {28'd0, retired},
                {28'd0, tv[i].ret});
        end

        // Illegal opcode traps; retired stays frozen
        step(6'h3f, 0, 0, 1);
        chk("ill_fetch", 32'(dcw), 32'(F1));
        chk("ill_ret0", {28'd0, retired}, 32'd9);
        step(6'h3f, 0, 0, 1);
        chk("ill_dec", 32'(dcw), 32'(DEC));
        for (int k = 0; k < 3; k++) begin
            step(6'h3f, 0, 0, 1);
            chk("ill_ctrl", 32'(dcw), 32'd0);
            chk("ill_fault", {31'd0, fault}, 32'd1);
            chk("ill_code", {30'd0, fault_code}, 32'd1);
            chk("ill_ret", {28'd0, retired}, 32'd9);
        end
        do_reset();

        // Unsupported R-type funct traps
        step(OP_R, 6'b000111, 0, 1);
        step(OP_R, 6'b000111, 0, 1);
        chk("fn_dec", 32'(dcw), 32'(DEC));
        step(OP_R, 6'b000111, 0, 1);
        chk("fn_fault", {31'd0, fault}, 32'd1);
        chk("fn_code", {30'd0, fault_code}, 32'd1);
        chk("fn_ctrl", 32'(dcw), 32'd0);
        do_reset();

        // Fetch never answered: faults after four wait cycles
        for (int k = 0; k < 4; k++) begin
            step(OP_J, 0, 0, 0);
            chk("to_wait", 32'(dcw), 32'(F0));
            chk("to_nofault", {31'd0, fault}, 32'd0);
        end
        step(OP_J, 0, 0, 0);
        chk("to_ctrl", 32'(dcw), 32'd0);
        chk("to_fault", {31'd0, fault}, 32'd1);
        chk("to_code", {30'd0, fault_code}, 32'd2);
        do_reset();

        // Ready on the last allowed cycle: no fault
        for (int k = 0; k < 3; k++) step(OP_J, 0, 0, 0);
        step(OP_J, 0, 0, 1);
        chk("edge_fetch", 32'(dcw), 32'(F1));
        step(OP_J, 0, 0, 1);
        chk("edge_dec", 32'(dcw), 32'(DEC));
        chk("edge_nofault", {31'd0, fault}, 32'd0);
        step(OP_J, 0, 0, 1);
        chk("edge_jmp", 32'(dcw), 32'(JMP));
        step(OP_J, 0, 0, 1);
        chk("edge_ret", {28'd0, retired}, 32'd1);
        do_reset();

        // Sixteen jumps wrap the 4-bit retired counter
        for (int k = 0; k < 16; k++) begin
            step(OP_J, 0, 0, 1);
            step(OP_J, 0, 0, 1);
            step(OP_J, 0, 0, 1);
            chk("wrap_jmp", 32'(dcw), 32'(JMP));
            chk("wrap_ret", {28'd0, retired}, 32'(k));
        end
        step(OP_J, 0, 0, 1);
        chk("wrap_zero", {28'd0, retired}, 32'd0);
        chk("wrap_fetch", 32'(dcw), 32'(F1));

        // Reset during a stalled store drops the request at once
        step(OP_SW, 0, 0, 1);
        step(OP_SW, 0, 0, 1);
        step(OP_SW, 0, 0, 0);
        step(OP_SW, 0, 0, 0);
        chk("swr_req", 32'(dcw), 32'(MWR));
        #2;
        reset_n = 1'b0;
        #1;
        chk("swr_drop", {31'd0, bus.mem_write}, 32'd0);
        chk("swr_iord", {31'd0, bus.iord}, 32'd0);
        chk("swr_ctrl", 32'(dcw), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("swr_idle", 32'(dcw), 32'd0);
        step(OP_J, 0, 0, 1);
        chk("swr_fetch", 32'(dcw), 32'(F1));
        chk("swr_ret", {28'd0, retired}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle successor to the single-cycle MIPS control decoder.
- An FSM sequences fetch, decode, execute, memory and writeback over several cycles, sharing one ALU and one memory port.
- Adds branch/jump, a variable-latency memory handshake with a timeout, illegal-instruction trapping and a retired-instruction counter.
- Sits between the instruction register/datapath and the unified memory port.

Parameters:
ALUOP_W, 6, width of alu_op; carries MIPS funct encoding (ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, SLT 101010, SLTU 101011), zero-extended or truncated to ALUOP_W.
MEM_TIMEOUT, 16, max cycles a memory state may wait for mem_ready before faulting (>=2).
CNT_W, 32, width of retired counter.

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
opcode  in  6  instruction[31:26], from instruction register
func  in  6  instruction[5:0]
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes current access this cycle
mem_read  out  1  memory read request
mem_write  out  1  memory write request
iord  out  1  0 = address from PC, 1 = from ALUOut
ir_write  out  1  load instruction register
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load qualified by branch outcome (already resolved internally)
pc_src  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target
alu_src_a  out  1  0 = PC, 1 = rs
alu_src_b  out  2  0 = rt, 1 = const 4, 2 = sign-ext imm, 3 = sign-ext imm<<2
alu_op  out  ALUOP_W  ALU operation, funct encoding
reg_dst  out  1  1 = rd, 0 = rt
mem_to_reg  out  1  1 = MDR, 0 = ALUOut
reg_write  out  1  register file write
fault  out  1  sticky fault indication
fault_code  out  2  01 = illegal opcode/funct, 10 = memory timeout
retired  out  CNT_W  count of completed instructions

Behaviour:
- Reset (reset_n low, asynchronous):
  - State = IDLE, retired = 0, timeout counter = 0, fault = 0, fault_code = 00.
  - All control outputs 0.
  - Reset mid-access aborts the access immediately.
- IDLE: all outputs 0; goes to FETCH on the next edge.
- FETCH:
  - Outputs: mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=ADD, pc_src=0.
  - ir_write and pc_write equal mem_ready (Mealy).
  - mem_ready=1: go to DECODE; else stay.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=3, alu_op=ADD (branch target into ALUOut).
  - Next state by opcode:
    - 000000 -> EXEC_R if func is one of the seven supported codes, else FAULT (code 01).
    - 100011/101011 -> MEM_ADDR.
    - ADDI 001000, ANDI 001100, ORI 001101, XORI 001110, SLTI 001010, SLTIU 001011 -> EXEC_I.
    - BEQ 000100, BNE 000101 -> BRANCH.
    - J 000010 -> JUMP.
    - Any other opcode -> FAULT (code 01).
- EXEC_R: alu_src_a=1, alu_src_b=0, alu_op=func -> WB_R.
- WB_R: reg_dst=1, mem_to_reg=0, reg_write=1 -> FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=2, alu_op mapped from opcode (ADDI->ADD, ANDI->AND, ORI->OR, XORI->XOR, SLTI->SLT, SLTIU->SLTU) -> WB_I.
- WB_I: reg_dst=0, mem_to_reg=0, reg_write=1 -> FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_op=ADD -> MEM_RD (LW) or MEM_WR (SW).
- MEM_RD: mem_read=1, iord=1. mem_ready -> WB_MEM; else stay.
- WB_MEM: reg_dst=0, mem_to_reg=1, reg_write=1 -> FETCH.
- MEM_WR: mem_write=1, iord=1. mem_ready -> FETCH; else stay.
- BRANCH:
  - Outputs: alu_src_a=1, alu_src_b=0, alu_op=SUB, pc_src=1.
  - pc_write_cond = zero for BEQ, !zero for BNE.
  - Goes to FETCH.
- JUMP: pc_write=1, pc_src=2 -> FETCH.
- FAULT:
  - All control outputs 0; fault=1; fault_code held.
  - Exit only by reset.
- Timeout:
  - Counter clears on entry to FETCH, MEM_RD or MEM_WR; increments each waiting cycle (mem_ready=0).
  - If mem_ready=0 while count == MEM_TIMEOUT-1: go to FAULT with code 10; the request drops the next cycle.
  - mem_ready=1 in the same cycle as expiry: the access completes and there is no fault.
- Requests stay stable while waiting: mem_read/mem_write/iord do not toggle until mem_ready.
- retired:
  - Increments by 1 on the final cycle of each instruction: WB_R, WB_I, WB_MEM, MEM_WR when mem_ready=1, BRANCH (taken or not), JUMP.
  - Wraps modulo 2^CNT_W; no increment in FAULT.
- Latency with zero-wait memory (mem_ready tied 1), cycles per instruction: R 4, I 4, LW 5, SW 4, BEQ/BNE 3, J 3. Each memory wait cycle adds 1.

Test Plan:
- mem_ready=1; ADD (opcode 000000, func 100000) -> FETCH, DECODE, EXEC_R (alu_op=100000), WB_R (reg_write=1, reg_dst=1); retired 0->1 after 4 cycles.
- LW with mem_ready low for 3 cycles in MEM_RD -> mem_read/iord held 3 cycles, WB_MEM with mem_to_reg=1 follows; total 8 cycles; retired +1.
- BEQ with zero=1, then BNE with zero=1 -> pc_write_cond=1 then 0; each takes 3 cycles.
- Opcode 111111; separately R-type func 000111 -> FAULT, fault=1, fault_code=01, all controls 0, retired frozen; reset_n low clears fault.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> FAULT with code 10 after 4 cycles; repeat with mem_ready=1 exactly on cycle 4 -> no fault.
- CNT_W=4, 16 J instructions -> retired wraps 15->0; assert reset_n low mid-MEM_WR -> mem_write drops asynchronously, state IDLE.
